// File: rtl/sec_sched_pkg.sv
// Shared definitions for the security-domain scheduler: FSM states, the low domain id, and the round-robin successor.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package sec_sched_pkg;

    typedef enum logic {
        RUN   = 1'b0,
        SCRUB = 1'b1
    } state_t;

    localparam int LOW_DOM = 0;

    // Round-robin successor; wrapping back to the low domain is signalled by returning LOW_DOM.
    function automatic int next_dom(input int cur_dom, input int num_dom);
        return (cur_dom + 1 >= num_dom) ? LOW_DOM : cur_dom + 1;
    endfunction

endpackage

// File: rtl/quantum_timer.sv
// Free-running modulo-LIMIT counter with hold (pause) and synchronous clear; flags the last count.
// Latency: terminal is combinational on the current count; the wrap to 0 happens on the following edge.
// Backpressure: pause holds the count and suppresses terminal; clear forces 0 and suppresses terminal.
module quantum_timer #(
    parameter int LIMIT = 10,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pause,
    input  logic             clear,
    output logic [CNT_W-1:0] cnt,
    output logic             terminal
);

    assign terminal = !pause && !clear && (cnt == CNT_W'(LIMIT - 1));

    // Count up while running, wrapping at LIMIT-1; clear and reset both park the count at zero.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            cnt <= '0;
        end else if (terminal) begin
            cnt <= '0;
        end else if (!pause) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/sec_mode_scheduler.sv
// Time-multiplexes NUM_DOM security domains on one shared register; domain 0 is L, the rest H, with a scrub before re-entering L.
// Latency: domain change and switch_pulse appear one cycle after the terminal-count cycle; wr_ack/wr_err one cycle after the write.
// Backpressure: none; rejected writes are dropped and flagged via wr_err, pause only freezes the quantum count in RUN.
module sec_mode_scheduler
    import sec_sched_pkg::*;
#(
    parameter int NUM_DOM   = 3,
    parameter int DOM_W     = 2,
    parameter int QUANTUM   = 10,
    parameter int CNT_W     = 4,
    parameter int DATA_W    = 8,
    parameter int SCRUB_CYC = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pause,
    input  logic              wr_en,
    input  logic [DOM_W-1:0]  wr_dom,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DOM_W-1:0]  dom,
    output logic              is_high,
    output logic              scrubbing,
    output logic              switch_pulse,
    output logic              wr_ack,
    output logic              wr_err,
    output logic [DATA_W-1:0] rd_data
);

    localparam int SCRUB_W = (SCRUB_CYC > 1) ? $clog2(SCRUB_CYC) : 1;

    state_t             state;
    logic [DATA_W-1:0]  shared;
    logic [CNT_W-1:0]   q_cnt;
    logic               q_term;
    logic [SCRUB_W-1:0] s_cnt;
    logic               s_term;
    logic               wr_ok;
    logic [DOM_W-1:0]   nxt;

    // Write permission depends only on control state, never on data, so ack/err carry no H information.
    assign wr_ok = (state == RUN) && (wr_dom == dom);
    assign nxt   = DOM_W'(next_dom(int'(dom), NUM_DOM));

    // Quantum count is held at zero while scrubbing so the L domain starts a fresh quantum.
    quantum_timer #(
        .LIMIT (QUANTUM),
        .CNT_W (CNT_W)
    ) u_quantum (
        .clk      (clk),
        .reset    (reset),
        .pause    (pause),
        .clear    (state == SCRUB),
        .cnt      (q_cnt),
        .terminal (q_term)
    );

    // Scrub length counter only runs in SCRUB and ignores pause.
    quantum_timer #(
        .LIMIT (SCRUB_CYC),
        .CNT_W (SCRUB_W)
    ) u_scrub (
        .clk      (clk),
        .reset    (reset),
        .pause    (1'b0),
        .clear    (state == RUN),
        .cnt      (s_cnt),
        .terminal (s_term)
    );

    // Mode FSM: round-robin rotation in RUN, H->L wrap only through SCRUB, shared-register writes and their status.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= RUN;
            dom          <= '0;
            shared       <= '0;
            switch_pulse <= 1'b0;
            wr_ack       <= 1'b0;
            wr_err       <= 1'b0;
        end else begin
            switch_pulse <= 1'b0;
            wr_ack       <= wr_en && wr_ok;
            wr_err       <= wr_en && !wr_ok;
            case (state)
                RUN: begin
                    if (wr_en && wr_ok) begin
                        shared <= wr_data;
                    end
                    if (q_term) begin
                        if (nxt != '0) begin
                            dom          <= nxt;
                            switch_pulse <= 1'b1;
                        end else begin
                            state <= SCRUB;
                        end
                    end
                end
                SCRUB: begin
                    shared <= '0;
                    if (s_term) begin
                        state        <= RUN;
                        dom          <= DOM_W'(LOW_DOM);
                        switch_pulse <= 1'b1;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

    assign is_high   = (dom != '0);
    assign scrubbing = (state == SCRUB);
    assign rd_data   = (state == RUN) ? shared : '0;

    // Counters never run past their limits.
    assert property (@(posedge clk) disable iff (reset) q_cnt <= CNT_W'(QUANTUM - 1));
    assert property (@(posedge clk) disable iff (reset) s_cnt <= SCRUB_W'(SCRUB_CYC - 1));

endmodule

// File: tb/tb_sec_mode_scheduler.sv
// Bench for sec_mode_scheduler: directed timeline scenarios plus randomized traffic against a cycle-level reference model.
// Latency: expectations are queued at input time and compared one clock later by an independent monitor.
// Backpressure: n/a.
module tb_sec_mode_scheduler;

    localparam int NUM_DOM   = 3;
    localparam int DOM_W     = 2;
    localparam int QUANTUM   = 10;
    localparam int CNT_W     = 4;
    localparam int DATA_W    = 8;
    localparam int SCRUB_CYC = 2;

    if (QUANTUM - 1 >= (1 << CNT_W)) begin : g_cnt_chk
        $error("QUANTUM-1 does not fit in CNT_W");
    end
    if (3 - 1 >= (1 << 2)) begin : g_cnt4_chk
        $error("second configuration quantum does not fit");
    end

    logic              clk;
    logic              reset, pause, wr_en;
    logic [DOM_W-1:0]  wr_dom;
    logic [DATA_W-1:0] wr_data;
    logic [DOM_W-1:0]  dom;
    logic              is_high, scrubbing, switch_pulse, wr_ack, wr_err;
    logic [DATA_W-1:0] rd_data;

    logic              reset4, pause4, wr_en4;
    logic [1:0]        wr_dom4;
    logic [7:0]        wr_data4;
    logic [1:0]        dom4;
    logic              is_high4, scrub4, pulse4, ack4, err4;
    logic [7:0]        rd4;

    sec_mode_scheduler #(
        .NUM_DOM(NUM_DOM), .DOM_W(DOM_W), .QUANTUM(QUANTUM),
        .CNT_W(CNT_W), .DATA_W(DATA_W), .SCRUB_CYC(SCRUB_CYC)
    ) dut (
        .clk(clk), .reset(reset), .pause(pause), .wr_en(wr_en),
        .wr_dom(wr_dom), .wr_data(wr_data), .dom(dom), .is_high(is_high),
        .scrubbing(scrubbing), .switch_pulse(switch_pulse), .wr_ack(wr_ack),
        .wr_err(wr_err), .rd_data(rd_data)
    );

    sec_mode_scheduler #(
        .NUM_DOM(4), .DOM_W(2), .QUANTUM(3), .CNT_W(2), .DATA_W(8), .SCRUB_CYC(1)
    ) dut4 (
        .clk(clk), .reset(reset4), .pause(pause4), .wr_en(wr_en4),
        .wr_dom(wr_dom4), .wr_data(wr_data4), .dom(dom4), .is_high(is_high4),
        .scrubbing(scrub4), .switch_pulse(pulse4), .wr_ack(ack4),
        .wr_err(err4), .rd_data(rd4)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [DOM_W-1:0]  dom;
        logic              is_high;
        logic              scrubbing;
        logic              pulse;
        logic              ack;
        logic              err;
        logic [DATA_W-1:0] rd;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model state: which domain owns the slot, cycles used in its quantum, scrub cycles left, shared value.
    int                m_dom, m_used, m_scrub_left;
    logic [DATA_W-1:0] m_shared;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input logic rst, input logic p, input logic we,
                              input logic [DOM_W-1:0] wd, input logic [DATA_W-1:0] wdat);
        exp_t e;
        logic acc;
        logic pulse;
        pulse = 1'b0;
        if (rst) begin
            m_dom = 0; m_used = 0; m_scrub_left = 0; m_shared = '0;
            e.ack = 1'b0; e.err = 1'b0;
        end else begin
            acc   = (m_scrub_left == 0) && (int'(wd) == m_dom);
            e.ack = we && acc;
            e.err = we && !acc;
            if (m_scrub_left > 0) begin
                m_shared = '0;
                m_scrub_left--;
                if (m_scrub_left == 0) begin
                    m_dom = 0; m_used = 0; pulse = 1'b1;
                end
            end else begin
                if (we && acc) m_shared = wdat;
                if (!p) begin
                    m_used++;
                    if (m_used == QUANTUM) begin
                        m_used = 0;
                        if (m_dom == NUM_DOM - 1) m_scrub_left = SCRUB_CYC;
                        else begin
                            m_dom++; pulse = 1'b1;
                        end
                    end
                end
            end
        end
        e.dom       = DOM_W'(m_dom);
        e.is_high   = (m_dom != 0);
        e.scrubbing = (m_scrub_left > 0);
        e.pulse     = pulse;
        e.rd        = (m_scrub_left > 0) ? '0 : m_shared;
        exp_q.push_back(e);
    endtask

    // Drive one cycle of stimulus at the falling edge and queue what the model expects after the next rising edge.
    task automatic drive(input logic rst, input logic p, input logic we,
                         input logic [DOM_W-1:0] wd, input logic [DATA_W-1:0] wdat);
        @(negedge clk);
        reset = rst; pause = p; wr_en = we; wr_dom = wd; wr_data = wdat;
        model_step(rst, p, we, wd, wdat);
    endtask

    // Monitor: every cycle the DUT presents a full output word; compare it against the oldest queued expectation.
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            check("sb_dom",     32'(dom),          32'(mon_e.dom));
            check("sb_is_high", 32'(is_high),      32'(mon_e.is_high));
            check("sb_scrub",   32'(scrubbing),    32'(mon_e.scrubbing));
            check("sb_pulse",   32'(switch_pulse), 32'(mon_e.pulse));
            check("sb_ack",     32'(wr_ack),       32'(mon_e.ack));
            check("sb_err",     32'(wr_err),       32'(mon_e.err));
            check("sb_rd",      32'(rd_data),      32'(mon_e.rd));
        end
    end

    function automatic int exp_dom_run(input int c);
        if (c < 10) return 0;
        if (c < 20) return 1;
        if (c < 32) return 2;
        return 0;
    endfunction

    function automatic int exp_dom4(input int c);
        if (c < 12) return c / 3;
        if (c == 12) return 3;
        return (c - 13) / 3;
    endfunction

    function automatic int exp_dom_rst31(input int c);
        if (c < 10) return 0;
        if (c < 20) return 1;
        if (c <= 31) return 2;
        if (c < 42) return 0;
        return 1;
    endfunction

    logic              s_we;
    logic [DOM_W-1:0]  s_wd;
    logic [DATA_W-1:0] s_wdat;

    initial begin
        reset = 1'b1; pause = 1'b0; wr_en = 1'b0; wr_dom = '0; wr_data = '0;
        reset4 = 1'b1; pause4 = 1'b0; wr_en4 = 1'b0; wr_dom4 = '0; wr_data4 = '0;

        // Reset, then an unpaused run with legal, illegal and terminal-cycle writes; second config in parallel.
        drive(1'b1, 1'b0, 1'b0, '0, '0);
        drive(1'b1, 1'b0, 1'b0, '0, '0);
        for (int c = 0; c <= 40; c++) begin
            s_we = 1'b0; s_wd = '0; s_wdat = '0;
            if (c == 12) begin s_we = 1'b1; s_wd = 2'd1; s_wdat = 8'hA5; end
            if (c == 14) begin s_we = 1'b1; s_wd = 2'd0; s_wdat = 8'h77; end
            if (c == 29) begin s_we = 1'b1; s_wd = 2'd2; s_wdat = 8'h3C; end
            drive(1'b0, 1'b0, s_we, s_wd, s_wdat);
            reset4 = 1'b0;
            check("run_dom", 32'(dom), 32'(exp_dom_run(c)));
            check("run_scrub", 32'(scrubbing), 32'(c == 30 || c == 31));
            check("run_pulse", 32'(switch_pulse), 32'(c == 10 || c == 20 || c == 32));
            if (c == 0)  check("reset_rd", 32'(rd_data), 32'h0);
            if (c == 13) check("legal_wr_rd", 32'(rd_data), 32'hA5);
            if (c == 15) check("illegal_wr_err", 32'(wr_err), 32'h1);
            if (c == 15) check("illegal_wr_rd", 32'(rd_data), 32'hA5);
            if (c == 30) check("terminal_wr_ack", 32'(wr_ack), 32'h1);
            if (c == 30 || c == 31 || c == 32) check("scrub_rd_zero", 32'(rd_data), 32'h0);
            if (c <= 16) begin
                check("cfg4_dom", 32'(dom4), 32'(exp_dom4(c)));
                check("cfg4_scrub", 32'(scrub4), 32'(c == 12));
            end
        end

        // Pause for cycles 5-9 of domain 0 delays the first switch to cycle 15.
        drive(1'b1, 1'b0, 1'b0, '0, '0);
        for (int c = 0; c <= 20; c++) begin
            drive(1'b0, (c >= 5 && c <= 9), 1'b0, '0, '0);
            check("pause_dom", 32'(dom), 32'(c < 15 ? 0 : 1));
        end

        // Pause held through the scrub window does not stretch it.
        drive(1'b1, 1'b0, 1'b0, '0, '0);
        for (int c = 0; c <= 33; c++) begin
            drive(1'b0, (c == 30 || c == 31), 1'b0, '0, '0);
            check("pause_scrub_dom", 32'(dom), 32'(exp_dom_run(c)));
            check("pause_scrub_flag", 32'(scrubbing), 32'(c == 30 || c == 31));
        end

        // Reset in the middle of the scrub aborts it and restarts a full domain-0 quantum.
        drive(1'b1, 1'b0, 1'b0, '0, '0);
        for (int c = 0; c <= 43; c++) begin
            s_we = (c == 29); s_wd = 2'd2; s_wdat = 8'h5A;
            drive((c == 31), 1'b0, s_we, s_wd, s_wdat);
            check("midscrub_rst_dom", 32'(dom), 32'(exp_dom_rst31(c)));
            if (c == 32) check("midscrub_rst_scrub", 32'(scrubbing), 32'h0);
            if (c == 32) check("midscrub_rst_rd", 32'(rd_data), 32'h0);
        end

        // Randomized traffic: sparse resets, frequent pauses, writes from any (including nonexistent) domain.
        for (int i = 0; i < 3000; i++) begin
            drive(($urandom_range(0, 199) == 0), ($urandom_range(0, 3) == 0),
                  1'($urandom_range(0, 1)), DOM_W'($urandom_range(0, 3)),
                  DATA_W'($urandom_range(0, 255)));
        end

        drive(1'b0, 1'b0, 1'b0, '0, '0);
        repeat (3) @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sec_mode_scheduler.md
Name: sec_mode_scheduler

Overview:
- Parametrised successor to the fixed 3-state L/H mode machine: time-multiplexes NUM_DOM security domains on one shared data register.
- Domain 0 is L; domains 1..NUM_DOM-1 are H. A quantum timer rotates domains round-robin every QUANTUM cycles.
- The shared register carries the dependent label Par[dom].
- Adds what the old block lacked:
  - per-domain write gating;
  - pause;
  - a mandatory scrub phase that zeroes shared state before any H→L transition.
- Sits between domain requesters and the shared register; dom/is_high are consumed by label-checking logic downstream.

Parameters:
- NUM_DOM, 3, number of domains (≥2); domain 0 is L, all others H
- DOM_W, 2, width of domain index (≥ clog2(NUM_DOM))
- QUANTUM, 10, cycles per domain quantum (≥2)
- CNT_W, 4, quantum counter width (≥ clog2(QUANTUM))
- DATA_W, 8, shared register width
- SCRUB_CYC, 2, cycles spent zeroing before entering L (≥1)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- pause  in  1  freezes quantum counter while high (RUN only)
- wr_en  in  1  write request
- wr_dom  in  DOM_W  domain issuing the write
- wr_data  in  DATA_W  write data
- dom  out  DOM_W  current domain, label L
- is_high  out  1  dom != 0
- scrubbing  out  1  high during SCRUB state
- switch_pulse  out  1  one-cycle pulse in the first cycle of a new domain
- wr_ack  out  1  registered: previous-cycle write accepted
- wr_err  out  1  registered: previous-cycle write rejected
- rd_data  out  DATA_W  shared register when RUN, else 0

Behaviour:
- One clock and one reset: single clock clk; reset is synchronous and active-high.
- Reset values: state=RUN, dom=0, cnt=0, shared=0; scrubbing, switch_pulse, wr_ack and wr_err all 0. Reset mid-SCRUB or mid-quantum aborts immediately to these values.
- RUN state:
  - If pause=0, cnt increments each cycle; pause=1 holds cnt.
  - At terminal count (cnt==QUANTUM-1, pause=0), cnt←0.
  - If next=(dom+1) mod NUM_DOM is non-zero, dom←next and switch_pulse=1 the next cycle.
  - If next==0 and dom!=0, go to SCRUB with dom unchanged.
  - NUM_DOM wrap: dom NUM_DOM-1 → 0 only via SCRUB.
- SCRUB state:
  - shared←0 every cycle; scrub counter runs 0..SCRUB_CYC-1; pause ignored.
  - After SCRUB_CYC cycles: dom←0, state←RUN, cnt←0, switch_pulse=1.
- Writes:
  - Accepted iff state==RUN and wr_dom==dom: shared←wr_data, then wr_ack=1 the following cycle.
  - Otherwise, with wr_en=1, shared is unchanged and wr_err=1 the following cycle.
  - A write on the terminal-count cycle is accepted for the outgoing domain.
  - If that write triggers SCRUB, scrub overwrites it; no leak into L.
- Latency: the dom change is visible one cycle after the terminal-count cycle.
- rd_data is combinational from state/shared: 0 during SCRUB.
- Security invariant: no L-labelled output (dom, is_high, switch_pulse, scrubbing) depends on shared or wr_data. wr_ack/wr_err depend only on wr_en, wr_dom, dom and state.
- Counter widths saturate nowhere: QUANTUM-1 must fit CNT_W; the bench checks this at elaboration.

Decomposition:
- Package sec_sched_pkg:
  - state encoding (RUN=0, SCRUB=1);
  - LOW_DOM=0 constant;
  - helper function next_dom(dom, NUM_DOM).
- One sub-module: quantum_timer. It takes clk, reset, pause and clear, and provides cnt and terminal outputs. It is reused for both the quantum and the scrub counts (two instances, different limits).

Test Plan:
- Reset then run, defaults, pause=0 → dom=0 cycles 0–9, dom=1 at 10, dom=2 at 20; scrubbing=1 cycles 30–31; dom=0 at 32. switch_pulse at 10, 20 and 32.
- wr_en with wr_dom=1, wr_data=8'hA5 at cycle 12 → wr_ack=1 at 13, rd_data=8'hA5. Same write with wr_dom=0 → wr_err=1, rd_data unchanged.
- Domain-2 write of 8'h3C at cycle 29 (terminal) → accepted (wr_ack at 30). rd_data=0 during 30–31; rd_data=0 at 32 in domain 0.
- pause=1 for cycles 5–9 in domain 0 → dom=1 at cycle 15, not 10. pause during SCRUB has no effect (still 2 cycles).
- reset asserted at cycle 31 (mid-SCRUB) → next cycle dom=0, scrubbing=0, shared=0, cnt=0.
- NUM_DOM=4, QUANTUM=3, SCRUB_CYC=1 → dom sequence 0,1,2,3 on 3-cycle boundaries, one scrub cycle, then 0.
